// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline-stage register.
// Per-stage control widths derive from the packed ctrl structs via $bits().
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
    logic [4:0] rsvd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [3:0] mem_size;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] rsvd;
  } mem_wb_ctrl_t;

  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);
  localparam int IF_ID_CTRL_W  = 8;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One {ctrl, data, pc} slot register. Clear zeroes ctrl/data (turning the
// slot into a NOP) but keeps the PC; clear wins over load.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int                    CTRL_WIDTH = 16,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = ADDR_WIDTH'(PC_RESET_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic [CTRL_WIDTH-1:0] d_ctrl,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic [ADDR_WIDTH-1:0] d_pc,
  output logic [CTRL_WIDTH-1:0] q_ctrl,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic [ADDR_WIDTH-1:0] q_pc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_ctrl <= '0;
      q_data <= '0;
      q_pc   <= PC_RESET;
    end else if (clear) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
      q_pc   <= d_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: valid/ready handshake, 2-entry skid buffer,
// registered in_ready. Define PIPE_STAGE_STATS_EN for stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = ADDR_WIDTH'(PC_RESET_DEFAULT),
  parameter int                    CTRL_WIDTH = ID_EX_CTRL_W,
  parameter int                    DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [1:0]            occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           bubble_cycles
`endif
);

  pipe_state_t state, state_nxt;
  logic in_ready_q;
  logic in_fire, out_fire;
  logic main_ld, skid_ld, main_from_skid;

  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [ADDR_WIDTH-1:0] skid_pc;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready & ~stall;

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin
        state_nxt = ONE;
        main_ld   = 1'b1;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          state_nxt = TWO;
          skid_ld   = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        state_nxt      = ONE;
        main_ld        = 1'b1;
        main_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops any slot arriving this cycle as well as the held ones.
    if (flush) begin
      state_nxt = EMPTY;
      main_ld   = 1'b0;
      skid_ld   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
    end
  end

  pipe_entry #(
    .CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .PC_RESET(PC_RESET)
  ) u_main (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (main_ld),
    .clear  (flush),
    .d_ctrl (main_from_skid ? skid_ctrl : in_ctrl),
    .d_data (main_from_skid ? skid_data : in_data),
    .d_pc   (main_from_skid ? skid_pc   : in_pc),
    .q_ctrl (out_ctrl),
    .q_data (out_data),
    .q_pc   (out_pc)
  );

  pipe_entry #(
    .CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .PC_RESET(PC_RESET)
  ) u_skid (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (skid_ld),
    .clear  (flush),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .d_pc   (in_pc),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data),
    .q_pc   (skid_pc)
  );

`ifdef PIPE_STAGE_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (out_valid && (stall || !out_ready)) stall_cycles <= sat_inc32(stall_cycles);
      if (!out_valid) bubble_cycles <= sat_inc32(bubble_cycles);
    end
  end
`endif

endmodule
